// File: rtl/bpred_update_ctrl.sv
// Branch-predictor update controller: tracks in-flight branches in a FIFO and
// keeps the speculative and committed global histories. It also produces the
// registered counter-table update and mispredict pulses.
module bpred_update_ctrl #(
  parameter int BPRED_WIDTH = 8,
  parameter int DEPTH       = 4
) (
  input  logic                           i_Clk,
  input  logic                           i_Reset,
  input  logic                           i_Fetch_Valid,
  input  logic [31:0]                    i_Fetch_PC,
  input  logic                           i_Prediction,
  output logic [BPRED_WIDTH-1:0]         o_Lookup_Index,
  output logic                           o_Fetch_Ready,
  input  logic                           i_Resolve_Valid,
  input  logic                           i_ALU_Branch_Outcome,
  input  logic                           i_Flush,
  output logic                           o_Update_Enable,
  output logic [BPRED_WIDTH-1:0]         o_Update_Index,
  output logic                           o_Update_Outcome,
  output logic                           o_Mispredict,
  output logic [$clog2(DEPTH+1)-1:0]     o_Count,
  output logic [BPRED_WIDTH-1:0]         o_GHR
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(DEPTH - 1);

  logic [BPRED_WIDTH-1:0] ghr_spec, ghr_cmt, ghr_cmt_nxt;
  logic [PTR_W-1:0]       rd_ptr, wr_ptr;
  logic [CNT_W-1:0]       count;
  logic [BPRED_WIDTH-1:0] fifo_idx  [DEPTH];
  logic                   fifo_pred [DEPTH];

  logic                   pop, accept, mispred, discard;
  logic [BPRED_WIDTH-1:0] head_idx;
  logic                   head_pred;

  logic                   vld_p1;
  logic [BPRED_WIDTH-1:0] upd_idx_p1;
  logic                   upd_out_p1;
  logic                   mis_p1;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_C) ? '0 : p + PTR_W'(1);
  endfunction

  function automatic logic [BPRED_WIDTH-1:0] ghr_shift(
    input logic [BPRED_WIDTH-1:0] g, input logic b);
    return {g[BPRED_WIDTH-2:0], b};
  endfunction

  // Fetch/resolve decode, evaluated against the current-cycle occupancy
  always_comb begin
    o_Lookup_Index = i_Fetch_PC[BPRED_WIDTH+1:2] ^ ghr_spec;
    o_Fetch_Ready  = (count < DEPTH_C);
    head_idx       = fifo_idx[rd_ptr];
    head_pred      = fifo_pred[rd_ptr];
    pop            = i_Resolve_Valid && (count != '0);
    mispred        = pop && (head_pred != i_ALU_Branch_Outcome);
    ghr_cmt_nxt    = pop ? ghr_shift(ghr_cmt, i_ALU_Branch_Outcome) : ghr_cmt;
    discard        = i_Flush || mispred;
    accept         = i_Fetch_Valid && o_Fetch_Ready && !discard;
  end

  // Queue control and history registers
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      ghr_spec <= '0;
      ghr_cmt  <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      ghr_cmt <= ghr_cmt_nxt;
      if (discard) begin
        // Squash everything younger; speculation restarts from the committed history
        rd_ptr   <= wr_ptr;
        count    <= '0;
        ghr_spec <= ghr_cmt_nxt;
      end else begin
        if (pop)
          rd_ptr <= ptr_inc(rd_ptr);
        if (accept) begin
          wr_ptr   <= ptr_inc(wr_ptr);
          ghr_spec <= ghr_shift(ghr_spec, i_Prediction);
        end
        if (accept && !pop)
          count <= count + CNT_W'(1);
        else if (pop && !accept)
          count <= count - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (accept) begin
      fifo_idx[wr_ptr]  <= o_Lookup_Index;
      fifo_pred[wr_ptr] <= i_Prediction;
    end
  end

  // Stage p1: registered update pulse; index/outcome held until the next pop
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      vld_p1     <= 1'b0;
      mis_p1     <= 1'b0;
      upd_idx_p1 <= '0;
      upd_out_p1 <= 1'b0;
    end else begin
      vld_p1 <= pop;
      mis_p1 <= mispred;
      if (pop) begin
        upd_idx_p1 <= head_idx;
        upd_out_p1 <= i_ALU_Branch_Outcome;
      end
    end
  end

  assign o_Update_Enable  = vld_p1;
  assign o_Update_Index   = upd_idx_p1;
  assign o_Update_Outcome = upd_out_p1;
  assign o_Mispredict     = mis_p1;
  assign o_Count          = count;
  assign o_GHR            = ghr_spec;

endmodule
